// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board geometry, cell layout and arbiter client ids
package board_pkg;

    localparam int ROWS   = 10;
    localparam int COLS   = 12;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    // One board cell as stored in the RAM word.
    typedef struct packed {
        logic [2:0]  owner;
        logic [1:0]  kind;
        logic [10:0] army;
    } cell_t;

    typedef enum logic [1:0] {
        CLI_VID = 2'd0,
        CLI_A   = 2'd1,
        CLI_B   = 2'd2
    } client_e;

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - per-client saturating wait counter with starvation flag
module arb_wait_counter #(
    parameter int LIMIT = 8,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic forced
);

    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] cnt;

    // Count cycles spent waiting; any grant or withdrawn request restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign forced = req && (cnt == MAX);

endmodule

// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - board RAM arbiter (video priority, A/B round-robin, starvation guard; stats via BOARD_ARB_STATS_EN)
module board_ram_arbiter
    import board_pkg::*;
#(
    parameter int ROWS         = board_pkg::ROWS,
    parameter int COLS         = board_pkg::COLS,
    parameter int ADDR_W       = board_pkg::ADDR_W,
    parameter int DATA_W       = board_pkg::DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    output logic              vid_drop,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              addr_err,
`ifdef BOARD_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_vid_gnt,
    output logic [15:0]       stat_a_gnt,
    output logic [15:0]       stat_b_gnt,
    output logic [15:0]       stat_vid_drop,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(ROWS * COLS);

    logic              a_forced, b_forced;
    logic              rr_b;          // 1 = B wins the next A/B tie
    logic              gnt_v, any_gnt, in_range, sel_we, preempt;
    logic [ADDR_W-1:0] sel_addr;
    logic              rd_vld, rd_zero;
    client_e           rd_cli;
    logic [DATA_W-1:0] rd_word, v_hold, a_hold, b_hold;

    arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait_a (
        .clock (clock), .reset (reset), .req (a_req), .gnt (a_gnt), .forced (a_forced)
    );

    arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait_b (
        .clock (clock), .reset (reset), .req (b_req), .gnt (b_gnt), .forced (b_forced)
    );

    // Single winner per cycle: starved client, then video, then round-robin A/B.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        gnt_v = 1'b0;
        if (!reset) begin
            if (a_forced && b_forced) begin
                b_gnt = rr_b;
                a_gnt = !rr_b;
            end else if (a_forced) begin
                a_gnt = 1'b1;
            end else if (b_forced) begin
                b_gnt = 1'b1;
            end else if (vid_req) begin
                gnt_v = 1'b1;
            end else if (a_req && b_req) begin
                b_gnt = rr_b;
                a_gnt = !rr_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    assign any_gnt   = gnt_v || a_gnt || b_gnt;
    assign preempt   = vid_req && (a_gnt || b_gnt);
    assign sel_addr  = a_gnt ? a_addr : (b_gnt ? b_addr : vid_addr);
    assign sel_we    = a_gnt ? a_we : (b_gnt ? b_we : 1'b0);
    assign in_range  = {1'b0, sel_addr} < CELLS;

    // Out-of-range accesses are granted but never reach the RAM.
    assign mem_en    = any_gnt && in_range;
    assign mem_we    = mem_en && sel_we;
    assign mem_addr  = sel_addr;
    assign mem_wdata = b_gnt ? b_wdata : a_wdata;

    // Track the read in flight, the round-robin pointer and the one-cycle status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld   <= 1'b0;
            rd_zero  <= 1'b0;
            rd_cli   <= CLI_VID;
            rr_b     <= 1'b0;
            addr_err <= 1'b0;
            vid_drop <= 1'b0;
        end else begin
            rd_vld   <= gnt_v || (a_gnt && !a_we) || (b_gnt && !b_we);
            rd_zero  <= !in_range;
            rd_cli   <= a_gnt ? CLI_A : (b_gnt ? CLI_B : CLI_VID);
            addr_err <= any_gnt && !in_range;
            vid_drop <= preempt;
            if (a_gnt) begin
                rr_b <= 1'b1;
            end else if (b_gnt) begin
                rr_b <= 1'b0;
            end
        end
    end

    assign rd_word    = rd_zero ? '0 : mem_rdata;
    assign vid_rvalid = rd_vld && (rd_cli == CLI_VID);
    assign a_rvalid   = rd_vld && (rd_cli == CLI_A);
    assign b_rvalid   = rd_vld && (rd_cli == CLI_B);
    assign vid_rdata  = vid_rvalid ? rd_word : v_hold;
    assign a_rdata    = a_rvalid ? rd_word : a_hold;
    assign b_rdata    = b_rvalid ? rd_word : b_hold;

    // Keep each requester's last returned word visible between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_hold <= '0;
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            if (vid_rvalid) v_hold <= rd_word;
            if (a_rvalid)   a_hold <= rd_word;
            if (b_rvalid)   b_hold <= rd_word;
        end
    end

`ifdef BOARD_ARB_STATS_EN
    // Saturating activity counters, clearable from software.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_vid_gnt  <= '0;
            stat_a_gnt    <= '0;
            stat_b_gnt    <= '0;
            stat_vid_drop <= '0;
        end else if (stat_clr) begin
            stat_vid_gnt  <= '0;
            stat_a_gnt    <= '0;
            stat_b_gnt    <= '0;
            stat_vid_drop <= '0;
        end else begin
            if (gnt_v   && stat_vid_gnt  != 16'hFFFF) stat_vid_gnt  <= stat_vid_gnt + 16'd1;
            if (a_gnt   && stat_a_gnt    != 16'hFFFF) stat_a_gnt    <= stat_a_gnt + 16'd1;
            if (b_gnt   && stat_b_gnt    != 16'hFFFF) stat_b_gnt    <= stat_b_gnt + 16'd1;
            if (preempt && stat_vid_drop != 16'hFFFF) stat_vid_drop <= stat_vid_drop + 16'd1;
        end
    end
`endif

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Shares the single-port board-cell RAM (ROWS x COLS cells, row-major) among three requesters: the video cell fetch path (renderer side of the pixel pipeline), the game-logic update port (A) and the turn-tick growth sweeper port (B).
- Video has priority. A and B alternate round-robin.
- A starvation guard guarantees A/B progress during long active-video bursts.
- Sits between game player, sweeper and board RAM. Drives the RAM port directly.

Parameters:
- ROWS, 10, board rows
- COLS, 12, board columns
- ADDR_W, 7, cell address width (must satisfy 2^ADDR_W >= ROWS*COLS)
- DATA_W, 16, cell word width (owner, army count, type)
- STARVE_LIMIT, 8, wait cycles after which a pending A/B request overrides video

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vid_req  in  1  video fetch request, one cycle per request
- vid_addr  in  ADDR_W  video cell address
- vid_rdata  out  DATA_W  video read data
- vid_rvalid  out  1  vid_rdata valid pulse
- vid_drop  out  1  video request was not served
- a_req / b_req  in  1  client request, level, held until gnt
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  client address
- a_wdata / b_wdata  in  DATA_W  client write data
- a_gnt / b_gnt  out  1  grant pulse, combinational in the request cycle
- a_rdata / b_rdata  out  DATA_W  client read data
- a_rvalid / b_rvalid  out  1  read data valid pulse
- addr_err  out  1  out-of-range access pulse
- mem_en, mem_we  out  1  RAM enable and write strobe
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en

Behaviour:
- Reset, asynchronous, any cycle: all registered outputs 0, wait counters 0, round-robin pointer = A, all in-flight rvalid/drop pulses cancelled.
- At most one grant per cycle.
- Grant order per cycle T:
  - forced client (wait counter == STARVE_LIMIT; if both A and B forced, the round-robin pointer decides);
  - then vid_req;
  - then A/B by round-robin pointer.
- Pointer update: moves to the other client after an A or B grant. Unchanged on a video grant or idle cycle.
- Grant in cycle T drives mem_* in cycle T:
  - write: mem_we = 1, mem_wdata = client wdata;
  - read: the requester's rvalid pulses at T+1 with rdata = mem_rdata.
- Client rdata holds its last value otherwise. Writes produce no rvalid.
- Client handshake:
  - addr, we and wdata stay stable while req = 1 and gnt = 0;
  - if req is still 1 in the cycle after gnt, it is a new request;
  - dropping req before gnt withdraws the request.
- Wait counter per client:
  - increments when req = 1 and gnt = 0, saturating at STARVE_LIMIT;
  - clears on gnt or when req = 0.
- Video preempted in cycle T: vid_drop pulses at T+1, vid_rvalid stays 0, vid_rdata holds its value. Video requests are never queued.
- Out-of-range address (addr >= ROWS*COLS):
  - the grant is still given, but mem_en = 0;
  - a read returns rdata = 0 with rvalid;
  - a write is discarded;
  - addr_err pulses at T+1.
- Latency: read, 1 cycle from grant; grant, 0 cycles when uncontended.

Optional Feature:
- Macro: BOARD_ARB_STATS_EN.
- Defined: adds 16-bit saturating counters stat_vid_gnt, stat_a_gnt, stat_b_gnt, stat_vid_drop as outputs, cleared by reset and by the extra input stat_clr (synchronous, 1 cycle).
- Undefined: these ports and counters do not exist. Arbitration is identical in both builds.

Decomposition:
- Shared package board_pkg holds:
  - ROWS, COLS, ADDR_W, DATA_W;
  - typedef cell_t (packed owner[2:0], kind[1:0], army[10:0]);
  - typedef client_e {CLI_VID, CLI_A, CLI_B}.
- One sub-module, arb_wait_counter: the per-client saturating wait counter with forced flag, instantiated twice (A and B).

Test Plan:
- Reset, then A read of addr 5 with RAM[5] = 16'h0123, no other requests → a_gnt in the same cycle, a_rvalid = 1 and a_rdata = 16'h0123 one cycle later.
- A and B request reads every cycle, video idle → grants alternate A, B, A, B…, starting with A after reset.
- vid_req held continuously with A requesting:
  - a_gnt in cycle 9 after the A request first cycle (8 wait cycles, then forced);
  - vid_drop = 1 the following cycle, then video resumes being served.
- A write addr 120 (out of range) → mem_en = 0, addr_err pulses next cycle, no rvalid; RAM contents unchanged.
- B write addr 7 data 16'hBEEF, then video read addr 7 → vid_rvalid with 16'hBEEF.
- reset asserted the cycle after an A read grant → a_rvalid never pulses, all outputs 0 immediately.
